// File: rtl/move_sequencer_if.sv
// Write channel from the move sequencer to the board store: one cell-write per
// legal move, held stable until the store raises wr_ready.
interface move_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_player;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_col,
        output wr_player,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_col,
        input  wr_player,
        output wr_ready
    );
endinterface

// File: rtl/move_sequencer.sv
// Turn/move controller: confirm-press detection, column legality check and board-store writes.
// Optional feature macro: STRICT_TURN_EN (only the key of the player to move is accepted).
module move_sequencer #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              column_i,
    input  logic                    confirm1_i,
    input  logic                    confirm2_i,
    move_sequencer_if.master        wr,
    output logic [1:0]              current_player_o,
    output logic                    reject_o,
    output logic [5:0]              move_count_o,
    output logic                    board_full_o
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    localparam logic [5:0] TOTAL_CELLS = 6'(COLS * ROWS);
    localparam logic [3:0] COLS_W      = 4'(COLS);
    localparam logic [2:0] ROWS_W      = 3'(ROWS);

    state_e     state_q, state_d;
    logic       prev1_q, prev2_q;
    logic [2:0] req_col_q, req_col_d;
    logic [2:0] height_q [COLS];
    logic [2:0] height_d [COLS];
    logic       wr_valid_q, wr_valid_d;
    logic [2:0] wr_row_q, wr_row_d;
    logic [2:0] wr_col_q, wr_col_d;
    logic [1:0] wr_player_q, wr_player_d;
    logic [1:0] player_q, player_d;
    logic       reject_q, reject_d;
    logic [5:0] count_q, count_d;
    logic       full_q, full_d;

    logic       press1_s, press2_s, accept_s;
    logic [2:0] sel_height_s;
    logic       move_legal_s;
    logic       handshake_s;
    logic [5:0] count_inc_s;

    assign press1_s = confirm1_i & ~prev1_q;
    assign press2_s = confirm2_i & ~prev2_q;

`ifdef STRICT_TURN_EN
    assign accept_s = (press1_s && (player_q == 2'd1)) || (press2_s && (player_q == 2'd2));
`else
    assign accept_s = press1_s || press2_s;
`endif

    assign handshake_s = (state_q == ST_WRITE) && wr_valid_q && wr.wr_ready;
    assign count_inc_s = count_q + 6'd1;

    // Fill height of the requested column; out-of-range columns read as zero.
    always_comb begin
        sel_height_s = 3'd0;
        for (int c = 0; c < COLS; c++) begin
            sel_height_s = (req_col_q == 3'(c)) ? height_q[c] : sel_height_s;
        end
    end

    assign move_legal_s = ({1'b0, req_col_q} < COLS_W) && (sel_height_s != ROWS_W);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (accept_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (move_legal_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (handshake_s) begin
                    state_d = (count_inc_s == TOTAL_CELLS) ? ST_FULL : ST_WAIT;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Output and datapath next-values; everything here lands in a register.
    always_comb begin
        req_col_d   = req_col_q;
        wr_valid_d  = wr_valid_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_player_d = wr_player_q;
        player_d    = player_q;
        reject_d    = 1'b0;
        count_d     = count_q;
        full_d      = full_q;
        for (int c = 0; c < COLS; c++) begin
            height_d[c] = height_q[c];
        end

        case (state_q)
            ST_WAIT: begin
                if (accept_s) begin
                    req_col_d = column_i;
                end else begin
                    req_col_d = req_col_q;
                end
            end
            ST_CHECK: begin
                if (move_legal_s) begin
                    wr_valid_d  = 1'b1;
                    wr_row_d    = sel_height_s;
                    wr_col_d    = req_col_q;
                    wr_player_d = player_q;
                end else begin
                    reject_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                if (handshake_s) begin
                    wr_valid_d = 1'b0;
                    count_d    = count_inc_s;
                    full_d     = (count_inc_s == TOTAL_CELLS);
                    player_d   = (player_q == 2'd1) ? 2'd2 : 2'd1;
                    for (int c = 0; c < COLS; c++) begin
                        height_d[c] = (req_col_q == 3'(c)) ? height_q[c] + 3'd1 : height_q[c];
                    end
                end else begin
                    wr_valid_d = 1'b1;
                end
            end
            ST_FULL: begin
                full_d = 1'b1;
            end
            default: begin
                wr_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; key history is sampled in every state so a held key never re-fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev1_q     <= 1'b0;
            prev2_q     <= 1'b0;
            req_col_q   <= 3'd0;
            wr_valid_q  <= 1'b0;
            wr_row_q    <= 3'd0;
            wr_col_q    <= 3'd0;
            wr_player_q <= 2'd0;
            player_q    <= 2'd1;
            reject_q    <= 1'b0;
            count_q     <= 6'd0;
            full_q      <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= 3'd0;
            end
        end else begin
            prev1_q     <= confirm1_i;
            prev2_q     <= confirm2_i;
            req_col_q   <= req_col_d;
            wr_valid_q  <= wr_valid_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            wr_player_q <= wr_player_d;
            player_q    <= player_d;
            reject_q    <= reject_d;
            count_q     <= count_d;
            full_q      <= full_d;
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= height_d[c];
            end
        end
    end

    assign wr.wr_valid      = wr_valid_q;
    assign wr.wr_row        = wr_row_q;
    assign wr.wr_col        = wr_col_q;
    assign wr.wr_player     = wr_player_q;
    assign current_player_o = player_q;
    assign reject_o         = reject_q;
    assign move_count_o     = count_q;
    assign board_full_o     = full_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: directed moves push expected writes/rejects,
// a monitor pops and compares each write handshake and reject pulse.
module tb_move_sequencer;

    typedef struct packed {
        logic       is_rej;
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] player;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] column;
    logic       confirm1, confirm2;
    logic [1:0] current_player;
    logic       reject;
    logic [5:0] move_count;
    logic       board_full;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    move_sequencer_if wr_if ();

    move_sequencer #(.COLS(7), .ROWS(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .column_i         (column),
        .confirm1_i       (confirm1),
        .confirm2_i       (confirm2),
        .wr               (wr_if),
        .current_player_o (current_player),
        .reject_o         (reject),
        .move_count_o     (move_count),
        .board_full_o     (board_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_event(input exp_t got);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got rej=%0d row=%0d col=%0d player=%0d with nothing expected",
                     got.is_rej, got.row, got.col, got.player);
        end else begin
            e = exp_q.pop_front();
            if (got != e) begin
                miscompares++;
                $display("FAIL event: got rej=%0d row=%0d col=%0d player=%0d expected rej=%0d row=%0d col=%0d player=%0d",
                         got.is_rej, got.row, got.col, got.player, e.is_rej, e.row, e.col, e.player);
            end
        end
    endtask

    // Monitor: samples just after the falling edge, when next-edge inputs are settled.
    always begin
        @(negedge clk);
        #1;
        if (!reset && wr_if.wr_valid && wr_if.wr_ready) begin
            check_event({1'b0, wr_if.wr_row, wr_if.wr_col, wr_if.wr_player});
        end
        if (!reset && reject) begin
            check_event({1'b1, 3'd0, 3'd0, 2'd0});
        end
    end

    task automatic push_write(input int row, input int col, input int player);
        exp_q.push_back({1'b0, 3'(row), 3'(col), 2'(player)});
    endtask

    task automatic push_reject();
        exp_q.push_back({1'b1, 3'd0, 3'd0, 2'd0});
    endtask

    // One key tap; returns at the falling edge after the write handshake would complete.
    task automatic do_move(input int key, input int col);
        @(negedge clk);
        column = 3'(col);
        if (key == 1) confirm1 = 1'b1;
        else          confirm2 = 1'b1;
        @(negedge clk);
        confirm1 = 1'b0;
        confirm2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got_valid;
        reset           = 1'b1;
        column          = 3'd0;
        confirm1        = 1'b0;
        confirm2        = 1'b0;
        wr_if.wr_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_wr_valid", int'(wr_if.wr_valid), 0);
        chk("rst_player", int'(current_player), 1);
        chk("rst_count", int'(move_count), 0);
        chk("rst_full", int'(board_full), 0);
        chk("rst_reject", int'(reject), 0);

        // First move: column 3, player 1, latency checked cycle by cycle.
        push_write(0, 3, 1);
        @(negedge clk);
        column   = 3'd3;
        confirm1 = 1'b1;
        @(negedge clk);
        confirm1 = 1'b0;
        chk("lat_check_valid", int'(wr_if.wr_valid), 0);
        @(negedge clk);
        chk("lat_write_valid", int'(wr_if.wr_valid), 1);
        @(negedge clk);
        chk("lat_after_valid", int'(wr_if.wr_valid), 0);
        chk("m1_player", int'(current_player), 2);
        chk("m1_count", int'(move_count), 1);

        // Column 0 filled to the top, then one move too many.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_write(i, 0, (i % 2 == 0) ? 1 : 2);
            do_move((i % 2 == 0) ? 1 : 2, 0);
        end
        push_reject();
        do_move(1, 0);
        chk("col0_count", int'(move_count), 6);
        chk("col0_player", int'(current_player), 1);

        // Out-of-range column, then a key held for 20 cycles.
        push_reject();
        do_move(1, 7);
        chk("col7_count", int'(move_count), 6);
        chk("col7_player", int'(current_player), 1);
        push_write(0, 5, 1);
        @(negedge clk);
        column   = 3'd5;
        confirm1 = 1'b1;
        repeat (20) @(negedge clk);
        confirm1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_count", int'(move_count), 7);
        chk("hold_player", int'(current_player), 2);

        // Stalled write, then reset in the middle of the stall.
        wr_if.wr_ready = 1'b0;
        @(negedge clk);
        column   = 3'd2;
        confirm2 = 1'b1;
        @(negedge clk);
        confirm2 = 1'b0;
        got_valid = 0;
        for (int i = 0; i < 8 && got_valid == 0; i++) begin
            @(negedge clk);
            if (wr_if.wr_valid) got_valid = 1;
        end
        chk("stall_valid_seen", got_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", int'({wr_if.wr_valid, wr_if.wr_row, wr_if.wr_col, wr_if.wr_player}),
                int'({1'b1, 3'd0, 3'd2, 2'd2}));
        end
        chk("stall_count", int'(move_count), 7);
        do_reset();
        chk("rst_mid_valid", int'(wr_if.wr_valid), 0);
        chk("rst_mid_count", int'(move_count), 0);
        chk("rst_mid_player", int'(current_player), 1);
        wr_if.wr_ready = 1'b1;

        // Fill the board column by column; every column starts at row 0 after the reset.
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                int k;
                k = c * 6 + r;
                push_write(r, c, (k % 2 == 0) ? 1 : 2);
                do_move((k % 2 == 0) ? 1 : 2, c);
                if (k == 40) begin
                    chk("full_before_last", int'(board_full), 0);
                    chk("count_before_last", int'(move_count), 41);
                end
            end
        end
        chk("full_flag", int'(board_full), 1);
        chk("full_count", int'(move_count), 42);
        do_move(1, 3);
        do_move(2, 0);
        do_move(1, 7);
        chk("full_count_after", int'(move_count), 42);
        chk("full_flag_after", int'(board_full), 1);
        chk("full_player_after", int'(current_player), 1);

        // Wrong player's key while player 1 is to move.
        do_reset();
`ifdef STRICT_TURN_EN
        do_move(2, 4);
        chk("turn_count", int'(move_count), 0);
        chk("turn_player", int'(current_player), 1);
`else
        push_write(0, 4, 1);
        do_move(2, 4);
        chk("turn_count", int'(move_count), 1);
        chk("turn_player", int'(current_player), 2);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
